neuron_unit: RTL and testbench

Sequential multiply-accumulate neuron that executes one dot product per `start` pulse from the network controller and returns a one-cycle `finish` pulse. Operands are fetched serially through an index port, one `x`/`w` pair per cycle, from the input/weight memories. A bias is added, then ReLU and saturation produce a `DATA_W` result held on `y`. The `layer` input selects the fan-in, so the same instance serves both network layers.

---
 rtl/neuron_pkg.sv | 28 ++
 rtl/neuron_relu_sat.sv | 38 +++
 rtl/neuron_unit.sv | 165 ++++++++++++++++
 tb/tb_neuron_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// ============================================================================
// neuron_pkg
// Shared state encoding and default widths for the neuron MAC unit.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package neuron_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_FRAC_W = 4;
  localparam int DEF_ACC_W  = 20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MAC    = 3'd1,
    ST_BIAS   = 3'd2,
    ST_ACT    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/neuron_relu_sat.sv
// ============================================================================
// relu_sat
// Drops the fractional bits of the accumulator, zeroes negative values and
// clamps positive overflow to the largest DATA_W signed value.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module relu_sat
  import neuron_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  i_acc,
  output logic [DATA_W-1:0] o_y
);

  localparam logic signed [ACC_W-1:0] c_y_max = ACC_W'((2 ** (DATA_W - 1)) - 1);

  logic signed [ACC_W-1:0] w_shift;

  assign w_shift = $signed(i_acc) >>> FRAC_W;

  // ReLU then clamp to the positive DATA_W range.
  always_comb begin
    o_y = w_shift[DATA_W-1:0];
    if (w_shift[ACC_W-1]) begin
      o_y = '0;
    end else if (w_shift > c_y_max) begin
      o_y = c_y_max[DATA_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/neuron_unit.sv
// ============================================================================
// neuron_unit
// Serial multiply-accumulate neuron: N operand pairs are fetched one per cycle
// through idx, a bias is added, then ReLU/saturation yields y.
// Optional build macro: NEURON_ACC_SAT_EN (saturating accumulator updates).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module neuron_unit
  import neuron_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int N0     = 8,
  parameter int N1     = 4,
  localparam int IDX_W = (max2(N0, N1) > 1) ? $clog2(max2(N0, N1)) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              start,
  input  logic              layer,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] bias,
  output logic [IDX_W-1:0]  idx,
  output logic              busy,
  output logic              finish,
  output logic [DATA_W-1:0] y
);

  state_t r_state;
  state_t w_state_next;
  logic   w_busy;
  logic   w_finish;

  logic signed [ACC_W-1:0]    r_acc;
  logic        [IDX_W-1:0]    r_idx;
  logic        [IDX_W-1:0]    r_last;
  logic        [DATA_W-1:0]   r_y;

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_bias_ext;
  logic signed [ACC_W-1:0]    w_addend;
  logic signed [ACC_W-1:0]    w_acc_next;
  logic        [DATA_W-1:0]   w_y;

  assign w_prod     = $signed(x_in) * $signed(w_in);
  assign w_bias_ext = ACC_W'($signed(bias));

  // Select what the accumulator adds this cycle: a product in MAC, the
  // bias aligned to the fixed-point grid in BIAS.
  always_comb begin
    w_addend = '0;
    if (r_state == ST_MAC) begin
      w_addend = ACC_W'(w_prod);
    end else if (r_state == ST_BIAS) begin
      w_addend = w_bias_ext <<< FRAC_W;
    end
  end

`ifdef NEURON_ACC_SAT_EN
  logic [ACC_W:0] w_sum;

  assign w_sum = {r_acc[ACC_W-1], r_acc} + {w_addend[ACC_W-1], w_addend};

  // Clamp the accumulator when the extra sign bit disagrees (overflow).
  always_comb begin
    w_acc_next = w_sum[ACC_W-1:0];
    if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
      w_acc_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  // Plain two's-complement accumulation.
  always_comb begin
    w_acc_next = r_acc + w_addend;
  end
`endif

  relu_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_relu_sat (
    .i_acc (r_acc),
    .o_y   (w_y)
  );

  // State register; clr returns to IDLE ahead of any start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state sequencing and status outputs.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b1;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start) w_state_next = ST_MAC;
      end
      ST_MAC: begin
        if (r_idx == r_last) w_state_next = ST_BIAS;
      end
      ST_BIAS:   w_state_next = ST_ACT;
      ST_ACT:    w_state_next = ST_FINISH;
      ST_FINISH: begin
        w_finish     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Accumulator, operand index, fan-in latch and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc  <= '0;
      r_idx  <= '0;
      r_last <= '0;
      r_y    <= '0;
    end else if (clr) begin
      r_acc  <= '0;
      r_idx  <= '0;
      r_y    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc  <= '0;
            r_idx  <= '0;
            r_last <= layer ? IDX_W'(N1 - 1) : IDX_W'(N0 - 1);
          end
        end
        ST_MAC: begin
          r_acc <= w_acc_next;
          r_idx <= (r_idx == r_last) ? '0 : r_idx + 1'b1;
        end
        ST_BIAS: r_acc <= w_acc_next;
        ST_ACT:  r_y   <= w_y;
        default: ;
      endcase
    end
  end

  assign idx    = r_idx;
  assign busy   = w_busy;
  assign finish = w_finish;
  assign y      = r_y;

endmodule

`default_nettype wire

// File: tb/tb_neuron_unit.sv
// ============================================================================
// tb_neuron_unit
// Self-checking bench for neuron_unit: directed vector table, abort
// sequences and random dot products against a behavioural model. A second
// instance with ACC_W=16 shares the stimulus to exercise accumulator overflow.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neuron_unit;

  localparam int N0 = 8;
  localparam int N1 = 4;
`ifdef NEURON_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, clr, start, layer;
  logic [7:0] x_in, w_in, bias;
  logic [2:0] idx, idx16;
  logic       busy, finish, busy16, finish16;
  logic [7:0] y, y16;

  logic signed [7:0] xmem [8];
  logic signed [7:0] wmem [8];

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int exp_prev_y = 0;
  int last_finish_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous-read operand memories.
  always_comb begin
    x_in = xmem[idx];
    w_in = wmem[idx];
  end

  neuron_unit #(.DATA_W(8), .FRAC_W(4), .ACC_W(20), .N0(N0), .N1(N1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .layer(layer),
    .x_in(x_in), .w_in(w_in), .bias(bias),
    .idx(idx), .busy(busy), .finish(finish), .y(y)
  );

  neuron_unit #(.DATA_W(8), .FRAC_W(4), .ACC_W(16), .N0(N0), .N1(N1)) dut16 (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .layer(layer),
    .x_in(x_in), .w_in(w_in), .bias(bias),
    .idx(idx16), .busy(busy16), .finish(finish16), .y(y16)
  );

  typedef struct {
    bit layer;
    int x;
    int w;
    int b;
    bit hold;
    int ey;
    int ey16;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint fit(input longint v, input longint half);
    longint r;
    if (SAT) begin
      r = (v > half - 1) ? half - 1 : ((v < -half) ? -half : v);
    end else begin
      r = v & (2 * half - 1);
      if (r >= half) r = r - 2 * half;
    end
    return r;
  endfunction

  // Dot product, bias, floor shift, ReLU and clamp done with plain integers.
  function automatic int ref_y(input int n, input int accw, input int b);
    longint half = longint'(1) <<< (accw - 1);
    longint acc = 0;
    for (int i = 0; i < n; i++)
      acc = fit(acc + longint'(xmem[i]) * longint'(wmem[i]), half);
    acc = fit(acc + longint'(b) * 16, half);
    acc = acc >>> 4;
    if (acc < 0) return 0;
    if (acc > 127) return 127;
    return int'(acc);
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle
  // after FINISH, so consecutive calls run back-to-back.
  task automatic run_op(input bit lay, input int b, input bit hold,
                        input int ey, input int ey16, input bit check_period);
    int  n = lay ? N1 : N0;
    bit  idx_ok = 1'b1;
    bit  busy_ok = 1'b1;
    bit  ystab_ok = 1'b1;
    bit  got = 1'b0;
    int  c = 1;
    start = 1'b1;
    layer = lay;
    bias  = 8'(b);
    @(negedge clk);
    start = hold;
    layer = ~lay;
    while (c <= 40) begin
      if (finish) begin
        got = 1'b1;
        break;
      end
      if (c <= n && (idx !== 3'(c - 1) || idx16 !== idx)) idx_ok = 1'b0;
      if (busy !== 1'b1 || busy16 !== 1'b1) busy_ok = 1'b0;
      if (y !== 8'(exp_prev_y)) ystab_ok = 1'b0;
      @(negedge clk);
      c++;
    end
    chk("finish_seen", int'(got), 1);
    chk("latency", c, n + 3);
    chk("idx_seq", int'(idx_ok), 1);
    chk("busy_during", int'(busy_ok), 1);
    chk("y_held", int'(ystab_ok), 1);
    chk("y", int'(y), ey);
    chk("y16", int'(y16), ey16);
    chk("finish16", int'(finish16), 1);
    if (check_period) chk("period", cyc - last_finish_cyc, n + 4);
    last_finish_cyc = cyc;
    exp_prev_y = ey;
    start = 1'b0;
    @(negedge clk);
    chk("finish_pulse_end", int'({finish, busy, finish16}), 0);
  endtask

  vec_t vecs [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0,   16,   16,    0, 1'b0, 127, 127};
    vecs[1] = '{1'b1,   16,    8,   16, 1'b0,  48,  48};
    vecs[2] = '{1'b0,   16,  -16,    0, 1'b1,   0,   0};
    vecs[3] = '{1'b0,  127,  127,    0, 1'b0, 127, SAT ? 127 : 0};
    vecs[4] = '{1'b1, -128, -128, -128, 1'b0, 127, SAT ? 127 : 0};
    vecs[5] = '{1'b1,    3,    5,   -1, 1'b0,   2,   2};
    vecs[6] = '{1'b0,   -3,    5,    1, 1'b0,   0,   0};
    vecs[7] = '{1'b1,   20,   10,    0, 1'b1,  50,  50};

    rst = 1'b0; clr = 1'b0; start = 1'b0; layer = 1'b0; bias = '0;
    for (int j = 0; j < 8; j++) begin xmem[j] = '0; wmem[j] = '0; end

    // Reset state.
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_finish", int'(finish), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_idx", int'(idx), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors, chained back-to-back.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        xmem[j] = 8'(vecs[i].x);
        wmem[j] = 8'(vecs[i].w);
      end
      run_op(vecs[i].layer, vecs[i].b, vecs[i].hold, vecs[i].ey, vecs[i].ey16, i > 0);
    end

    // Abort with clr during MAC at idx 3 (operands 20/10 remain loaded).
    start = 1'b1; layer = 1'b0; bias = '0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (idx == 3'd3) break;
      @(negedge clk);
    end
    chk("clr_reach_idx3", int'(idx), 3);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_busy", int'(busy), 0);
    chk("clr_y", int'({y, y16}), 0);
    chk("clr_idx", int'(idx), 0);
    begin
      bit fin_seen = 1'b0;
      for (int k = 0; k < 15; k++) begin
        if (finish || finish16) fin_seen = 1'b1;
        @(negedge clk);
      end
      chk("clr_no_finish", int'(fin_seen), 0);
    end
    exp_prev_y = 0;
    run_op(1'b0, 0, 1'b0, 100, 100, 1'b0);

    // Abort with asynchronous reset during BIAS (layer 1: cycle 5).
    start = 1'b1; layer = 1'b1; bias = '0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_y", int'({y, y16}), 0);
    chk("arst_idx", int'(idx), 0);
    chk("arst_finish", int'(finish), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_prev_y = 0;
    run_op(1'b1, 0, 1'b0, 50, 50, 1'b0);

    // Random dot products against the model.
    for (int r = 0; r < 40; r++) begin
      bit lay = 1'(($urandom_range(0, 1)));
      int b = int'($urandom_range(0, 255)) - 128;
      int n;
      for (int j = 0; j < 8; j++) begin
        xmem[j] = 8'($urandom_range(0, 255));
        wmem[j] = 8'($urandom_range(0, 255));
      end
      n = lay ? N1 : N0;
      run_op(lay, b, 1'($urandom_range(0, 1)), ref_y(n, 20, b), ref_y(n, 16, b), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire
